// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then emits W[0..ROUNDS-1] from a 16-deep window.
// The first word appears 1 cycle after the 16th accept. w_ready low holds the output word and the window.

module sha256_sigma0 (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);
    assign o_y = {i_x[6:0], i_x[31:7]} ^ {i_x[17:0], i_x[31:18]} ^ (i_x >> 3);
endmodule

module sha256_sigma1 (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);
    assign o_y = {i_x[16:0], i_x[31:17]} ^ {i_x[18:0], i_x[31:19]} ^ (i_x >> 10);
endmodule

module msg_schedule #(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [5:0]            w_idx,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last
);
    typedef enum logic {S_LOAD, S_EMIT} state_t;

    localparam logic [5:0] LAST_IDX   = 6'(ROUNDS - 1);
    localparam logic [5:0] REFILL_LIM = 6'(ROUNDS - 16);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_win [16];
    logic [3:0]            r_cnt;
    logic [5:0]            r_idx;

    logic                  w_load_acc;
    logic                  w_emit_xfer;
    logic                  w_load_done;
    logic                  w_emit_done;
    logic                  w_shift;
    logic [DATA_WIDTH-1:0] w_s0;
    logic [DATA_WIDTH-1:0] w_s1;
    logic [DATA_WIDTH-1:0] w_refill;
    logic [DATA_WIDTH-1:0] w_shift_in;

    sha256_sigma0 u_s0 (.i_x(r_win[1]),  .o_y(w_s0));
    sha256_sigma1 u_s1 (.i_x(r_win[14]), .o_y(w_s1));

    // W[t+16] from the window holding W[t..t+15]
    assign w_refill = w_s1 + r_win[9] + w_s0 + r_win[0];

    assign in_ready    = (r_state == S_LOAD) && !rst;
    assign w_valid     = (r_state == S_EMIT);
    assign w_data      = r_win[0];
    assign w_idx       = r_idx;
    assign w_last      = w_valid && (r_idx == LAST_IDX);

    assign w_load_acc  = in_valid && in_ready;
    assign w_emit_xfer = w_valid && w_ready;
    assign w_load_done = w_load_acc && (r_cnt == 4'd15);
    assign w_emit_done = w_emit_xfer && (r_idx == LAST_IDX);
    assign w_shift     = w_load_acc || w_emit_xfer;

    // The last 16 refills are never emitted, so zero keeps the window tidy
    assign w_shift_in  = (r_state == S_LOAD)  ? in_data  :
                         (r_idx < REFILL_LIM) ? w_refill : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_load_done) w_state_nxt = S_EMIT;
            S_EMIT:  if (w_emit_done) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
        end else if (w_shift) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_shift_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            // 4-bit count wraps to 0 on the 16th accept
            if (w_load_acc) r_cnt <= r_cnt + 4'd1;
            if (w_emit_xfer) r_idx <= w_emit_done ? 6'd0 : r_idx + 6'd1;
        end
    end
endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: expected words from a FIPS 180-4 schedule model plus hand values.

module tb_msg_schedule;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] w_data;
    logic [5:0]  w_idx;
    logic        w_valid;
    logic        w_ready;
    logic        w_last;

    msg_schedule #(.DATA_WIDTH(32), .ROUNDS(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_data   (w_data),
        .w_idx    (w_idx),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_last   (w_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] blk_cur [16];
    logic [31:0] exp_w   [64];
    logic [31:0] got_w   [64];
    int          last_xfer_cyc;
    int          first_valid_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic build_expect();
        for (int t = 0; t < 16; t++) exp_w[t] = blk_cur[t];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk_cur[i] = 32'h0;
        blk_cur[0]  = 32'h61626380;
        blk_cur[15] = 32'h00000018;
        build_expect();
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) blk_cur[i] = 32'h0;
        build_expect();
    endtask

    // Drives n accepted words; when n is 16 also checks the first emitted word one cycle later
    task automatic load_block(input bit toggle, input int n);
        int acc   = 0;
        int guard = 0;
        bit ph    = 1'b1;
        while (acc < n && guard < 100) begin
            @(negedge clk);
            guard++;
            w_ready  = 1'b0;
            ph       = toggle ? !ph : 1'b1;
            in_valid = ph;
            in_data  = ph ? blk_cur[acc] : 32'hDEADBEEF;
            if (in_valid && in_ready) acc++;
        end
        chk("load_accepts", 32'(acc), 32'(n));
        if (n == 16) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 32'h0;
            first_valid_cyc = cyc;
            chk("first_valid", 32'(w_valid), 32'd1);
            chk("first_idx", 32'(w_idx), 32'd0);
            chk("first_data", w_data, blk_cur[0]);
            chk("emit_in_ready", 32'(in_ready), 32'd0);
        end
    endtask

    // mode 0: w_ready held high; mode 1: random w_ready
    task automatic collect(input int mode, input int n);
        int k     = 0;
        int guard = 0;
        while (k < n && guard < 1000) begin
            @(negedge clk);
            guard++;
            w_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_valid) begin
                chk($sformatf("w%0d_data", k), w_data, exp_w[k]);
                chk($sformatf("w%0d_idx", k), 32'(w_idx), 32'(k));
                chk($sformatf("w%0d_last", k), 32'(w_last), 32'(k == 63));
                chk($sformatf("w%0d_in_ready", k), 32'(in_ready), 32'd0);
                got_w[k] = w_data;
                if (w_ready) begin
                    if (k == 63) last_xfer_cyc = cyc;
                    k++;
                end
            end
        end
        chk("xfer_count", 32'(k), 32'(n));
    endtask

    task automatic end_block();
        @(negedge clk);
        w_ready = 1'b0;
        chk("done_valid", 32'(w_valid), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_idx", 32'(w_idx), 32'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        w_ready  = 1'b0;
        #1;
        chk("rst_in_ready_hi", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rst_valid", 32'(w_valid), 32'd0);
        chk("rst_last", 32'(w_last), 32'd0);
        chk("rst_data", w_data, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_idx", 32'(w_idx), 32'd0);
        chk("post_rst_valid", 32'(w_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        w_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(w_valid), 32'd0);
        chk("reset_last", 32'(w_last), 32'd0);
        chk("reset_data", w_data, 32'h0);
        chk("reset_idx", 32'(w_idx), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_rel_in_ready", 32'(in_ready), 32'd1);

        // "abc" block with hand-derived anchor words
        set_abc();
        load_block(1'b0, 16);
        collect(0, 64);
        chk("abc_w0", got_w[0], 32'h61626380);
        chk("abc_w15", got_w[15], 32'h00000018);
        chk("abc_w16", got_w[16], 32'h61626380);
        chk("abc_w17", got_w[17], 32'h000F0000);
        end_block();

        // all-zero block
        set_zero();
        load_block(1'b0, 16);
        collect(0, 64);
        chk("zero_w40", got_w[40], 32'h0);
        chk("zero_w63", got_w[63], 32'h0);
        end_block();

        // random backpressure on "abc"
        set_abc();
        load_block(1'b0, 16);
        collect(1, 64);
        chk("bp_w17", got_w[17], 32'h000F0000);
        end_block();

        // back-to-back blocks with in_valid held high through EMIT
        set_abc();
        load_block(1'b0, 16);
        in_valid = 1'b1;
        in_data  = 32'hA5A5A5A5;
        collect(0, 64);
        load_block(1'b0, 16);
        chk("b2b_gap", 32'(first_valid_cyc - last_xfer_cyc), 32'd17);
        collect(0, 64);
        end_block();

        // reset after 8 loaded words, then a clean block
        set_abc();
        load_block(1'b0, 8);
        pulse_rst();
        load_block(1'b0, 16);
        collect(0, 64);
        end_block();

        // reset at w_idx=20, then a clean block
        load_block(1'b0, 16);
        collect(0, 20);
        pulse_rst();
        load_block(1'b0, 16);
        collect(0, 64);
        chk("rst_emit_w16", got_w[16], 32'h61626380);
        end_block();

        // in_valid toggling during LOAD
        load_block(1'b1, 16);
        collect(0, 64);
        end_block();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
